// File: rtl/tach_rpm_scheduler_pkg.sv
// Shared types and constants for the tachometer RPM scheduler.
package tach_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DIV   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam int CLK_HZ         = 125000000;
    localparam int WINDOW_CYCLES  = 12500000;
    localparam int PULSES_PER_REV = 360;
    localparam int DIVISOR        = 6;

endpackage

// File: rtl/tach_rpm_scheduler_div6_seq.sv
// Sequential restoring divide-by-6: one quotient bit per cycle, CNT_W cycles after start.
module tach_div6_seq #(
    parameter int CNT_W = 24
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [CNT_W-1:0] dividend_in,
    output logic [CNT_W-1:0] quotient_out,
    output logic             done_out
);
    import tach_pkg::*;

    localparam int CW = $clog2(CNT_W + 1);

    logic [CNT_W-1:0] r_quo;
    logic [2:0]       r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [3:0]       w_trial;
    logic             w_ge;
    logic [2:0]       w_rem_next;

    // Trial subtraction; the remainder never exceeds 5 so 3 bits suffice.
    always_comb begin
        w_trial = {r_rem, r_quo[CNT_W-1]};
        w_ge    = (w_trial >= 4'(DIVISOR));
        if (w_ge) begin
            w_rem_next = 3'(w_trial - 4'(DIVISOR));
        end else begin
            w_rem_next = w_trial[2:0];
        end
    end

    // Dividend shifts out of the top while quotient bits shift in at the bottom.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_quo  <= '0;
            r_rem  <= 3'd0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (start_in) begin
            r_quo  <= dividend_in;
            r_rem  <= 3'd0;
            r_cnt  <= CW'(CNT_W);
            r_done <= 1'b0;
        end else if (r_cnt != '0) begin
            r_quo  <= {r_quo[CNT_W-2:0], w_ge};
            r_rem  <= w_rem_next;
            r_cnt  <= r_cnt - CW'(1);
            r_done <= (r_cnt == CW'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign quotient_out = r_quo;
    assign done_out     = r_done;

endmodule

// File: rtl/tach_rpm_scheduler.sv
// Multi-channel tachometer: gate window, per-channel edge counting, and a shared
// divide-by-6 scaler producing RPM = x + x/2 + x/6 for each channel in turn.
module tach_rpm_scheduler #(
    parameter int NUM_CH        = 2,
    parameter int WINDOW_CYCLES = tach_pkg::WINDOW_CYCLES,
    parameter int CNT_W         = 24,
    parameter int RPM_W         = 21
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    enable_in,
    input  logic [NUM_CH-1:0]       tach_pulse_in,
    output logic [NUM_CH*RPM_W-1:0] rpm_out,
    output logic [NUM_CH-1:0]       rpm_valid_out,
    output logic [NUM_CH-1:0]       sat_out,
    output logic                    frame_done_out,
    output logic                    busy_out
);
    import tach_pkg::*;

    localparam int WC_W  = $clog2(WINDOW_CYCLES);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DC_W  = $clog2(CNT_W);
    localparam int SUM_W = CNT_W + 2;
    localparam int EXT_W = ((SUM_W > RPM_W) ? SUM_W : RPM_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RPM_W-1:0] RPM_MAX = '1;
    localparam logic [EXT_W-1:0] RPM_LIM = EXT_W'(1) << RPM_W;

    if (NUM_CH * (CNT_W + 2) >= WINDOW_CYCLES) begin : g_bad_cfg
        $error("tach_rpm_scheduler: scaling a frame must finish inside one window");
    end

    logic [NUM_CH-1:0]             r_sync1, r_sync2, r_sync3, r_edge;
    logic [WC_W-1:0]               r_wcnt;
    logic [NUM_CH-1:0][CNT_W-1:0]  r_cnt, r_cap, w_cnt_inc;
    logic [NUM_CH-1:0]             r_cnt_sat, r_cap_sat, w_ovf;
    state_t                        r_state;
    logic [CH_W-1:0]               r_ch;
    logic [DC_W-1:0]               r_div_cnt;
    logic [CNT_W-1:0]              r_x;
    logic                          r_x_sat;
    logic [NUM_CH-1:0][RPM_W-1:0]  r_rpm;
    logic [NUM_CH-1:0]             r_valid, r_sat;
    logic                          r_frame, r_busy;
    logic                          w_term, w_div_start, w_div_done, w_rpm_ovf;
    logic [CNT_W-1:0]              w_quo;
    logic [SUM_W-1:0]              w_sum;
    logic [EXT_W-1:0]              w_sum_ext;
    logic [RPM_W-1:0]              w_rpm;

    assign w_term      = enable_in && (r_wcnt == WC_W'(WINDOW_CYCLES - 1));
    assign w_div_start = (r_state == S_LOAD);

    // Two-flop synchronizer plus a registered rising-edge strobe per channel.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_edge  <= '0;
        end else begin
            r_sync1 <= tach_pulse_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
        end
    end

    // Gate window counter; held at 0 while disabled.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wcnt <= '0;
        end else if (!enable_in || w_term) begin
            r_wcnt <= '0;
        end else begin
            r_wcnt <= r_wcnt + WC_W'(1);
        end
    end

    // Saturating increment; an edge arriving at full scale marks the window saturated.
    always_comb begin
        w_cnt_inc = r_cnt;
        w_ovf     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_edge[i] && (r_cnt[i] == CNT_MAX)) begin
                w_ovf[i] = 1'b1;
            end else if (r_edge[i]) begin
                w_cnt_inc[i] = r_cnt[i] + CNT_W'(1);
            end else begin
                w_ovf[i] = 1'b0;
            end
        end
    end

    // Edge counters; the terminal-cycle edge is folded into the closing capture.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_cnt     <= '0;
            r_cnt_sat <= '0;
            r_cap     <= '0;
            r_cap_sat <= '0;
        end else if (!enable_in) begin
            r_cnt     <= '0;
            r_cnt_sat <= '0;
        end else if (w_term) begin
            r_cap     <= w_cnt_inc;
            r_cap_sat <= r_cnt_sat | w_ovf;
            r_cnt     <= '0;
            r_cnt_sat <= '0;
        end else begin
            r_cnt     <= w_cnt_inc;
            r_cnt_sat <= r_cnt_sat | w_ovf;
        end
    end

    tach_div6_seq #(.CNT_W(CNT_W)) u_div (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .start_in     (w_div_start),
        .dividend_in  (r_cap[r_ch]),
        .quotient_out (w_quo),
        .done_out     (w_div_done)
    );

    // Sum is formed two bits wider than the count so it cannot wrap before clamping.
    always_comb begin
        w_sum     = SUM_W'(r_x) + SUM_W'(r_x >> 1) + SUM_W'(w_quo);
        w_sum_ext = EXT_W'(w_sum);
        w_rpm_ovf = (w_sum_ext >= RPM_LIM);
        if (w_rpm_ovf) begin
            w_rpm = RPM_MAX;
        end else begin
            w_rpm = w_sum_ext[RPM_W-1:0];
        end
    end

    // Scaler FSM walks the channels once per captured window.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_div_cnt <= '0;
            r_x       <= '0;
            r_x_sat   <= 1'b0;
            r_rpm     <= '0;
            r_sat     <= '0;
            r_valid   <= '0;
            r_frame   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= '0;
            r_frame <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_term) begin
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_x       <= r_cap[r_ch];
                    r_x_sat   <= r_cap_sat[r_ch];
                    r_div_cnt <= DC_W'(CNT_W - 1);
                    r_state   <= S_DIV;
                end
                S_DIV: begin
                    if (r_div_cnt == '0) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_div_cnt <= r_div_cnt - DC_W'(1);
                    end
                end
                S_WRITE: begin
                    if (w_div_done) begin
                        r_rpm[r_ch]   <= w_rpm;
                        r_sat[r_ch]   <= w_rpm_ovf | r_x_sat;
                        r_valid[r_ch] <= 1'b1;
                        if (r_ch == CH_W'(NUM_CH - 1)) begin
                            r_frame <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_ch    <= r_ch + CH_W'(1);
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rpm_out        = r_rpm;
    assign rpm_valid_out  = r_valid;
    assign sat_out        = r_sat;
    assign frame_done_out = r_frame;
    assign busy_out       = r_busy;

endmodule

// File: tb/tb_tach_rpm_scheduler.sv
// Scoreboard bench: three scheduler configurations share one clock and tach stimulus.
module tb_tach_rpm_scheduler;

    localparam int WIN = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  tach;

    logic [41:0] rpm_a, rpm_b;
    logic [11:0] rpm_c;
    logic [1:0]  val_a, val_b, val_c, sat_a, sat_b, sat_c;
    logic        fd_a, fd_b, fd_c, busy_a, busy_b, busy_c;

    tach_rpm_scheduler #(.NUM_CH(2), .WINDOW_CYCLES(WIN), .CNT_W(24), .RPM_W(21)) dut (
        .clk_in(clk), .reset_in(rst), .enable_in(en), .tach_pulse_in(tach),
        .rpm_out(rpm_a), .rpm_valid_out(val_a), .sat_out(sat_a),
        .frame_done_out(fd_a), .busy_out(busy_a));

    tach_rpm_scheduler #(.NUM_CH(2), .WINDOW_CYCLES(WIN), .CNT_W(8), .RPM_W(21)) dut_c8 (
        .clk_in(clk), .reset_in(rst), .enable_in(en), .tach_pulse_in(tach),
        .rpm_out(rpm_b), .rpm_valid_out(val_b), .sat_out(sat_b),
        .frame_done_out(fd_b), .busy_out(busy_b));

    tach_rpm_scheduler #(.NUM_CH(2), .WINDOW_CYCLES(WIN), .CNT_W(24), .RPM_W(6)) dut_r6 (
        .clk_in(clk), .reset_in(rst), .enable_in(en), .tach_pulse_in(tach),
        .rpm_out(rpm_c), .rpm_valid_out(val_c), .sat_out(sat_c),
        .frame_done_out(fd_c), .busy_out(busy_c));

    always #4 clk = ~clk;

    logic [20:0] rpm_s  [3][2];
    logic [1:0]  val_s  [3];
    logic [1:0]  sat_s  [3];
    logic        fd_s   [3];
    logic        busy_s [3];

    assign rpm_s[0][0] = rpm_a[20:0];
    assign rpm_s[0][1] = rpm_a[41:21];
    assign rpm_s[1][0] = rpm_b[20:0];
    assign rpm_s[1][1] = rpm_b[41:21];
    assign rpm_s[2][0] = {15'd0, rpm_c[5:0]};
    assign rpm_s[2][1] = {15'd0, rpm_c[11:6]};
    assign val_s[0] = val_a;   assign val_s[1] = val_b;   assign val_s[2] = val_c;
    assign sat_s[0] = sat_a;   assign sat_s[1] = sat_b;   assign sat_s[2] = sat_c;
    assign fd_s[0]  = fd_a;    assign fd_s[1]  = fd_b;    assign fd_s[2]  = fd_c;
    assign busy_s[0] = busy_a; assign busy_s[1] = busy_b; assign busy_s[2] = busy_c;

    typedef struct {
        int t_exp;
        int rpm;
        int sat;
    } exp_t;

    // act: 0 = plain window, 1 = reset at offset cut, 2 = enable drop at offset cut
    typedef struct {
        int n0; int x0; int n1; int x1;
        int act; int cut; int push; int busy10;
        int r0a; int s0a; int r1; int r0b; int s0b; int r0c; int s0c;
    } vec_t;

    exp_t q [6][$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Stream index = dut*2 + channel; strobe latency is 1+(ch+1)*(CNT_W+2) after the terminal cycle.
    task automatic push_exp(input int t, input vec_t v);
        exp_t e;
        e.t_exp = t + 27; e.rpm = v.r0a; e.sat = v.s0a; q[0].push_back(e);
        e.t_exp = t + 53; e.rpm = v.r1;  e.sat = 0;     q[1].push_back(e);
        e.t_exp = t + 11; e.rpm = v.r0b; e.sat = v.s0b; q[2].push_back(e);
        e.t_exp = t + 21; e.rpm = v.r1;  e.sat = 0;     q[3].push_back(e);
        e.t_exp = t + 27; e.rpm = v.r0c; e.sat = v.s0c; q[4].push_back(e);
        e.t_exp = t + 53; e.rpm = v.r1;  e.sat = 0;     q[5].push_back(e);
    endtask

    function automatic logic pulse(input int k, input int n, input int x);
        return ((k < 2 * n) && (k % 2 == 0)) || (k == x);
    endfunction

    task automatic check_idle(input int d);
        nvec++;
        if (rpm_s[d][0] !== 21'd0 || rpm_s[d][1] !== 21'd0 || sat_s[d] !== 2'b00 ||
            val_s[d] !== 2'b00 || fd_s[d] !== 1'b0 || busy_s[d] !== 1'b0) begin
            nerr++;
            $display("FAIL idle_d%0d: rpm0=%0d rpm1=%0d sat=%b valid=%b fd=%b busy=%b, required all zero",
                     d, rpm_s[d][0], rpm_s[d][1], sat_s[d], val_s[d], fd_s[d], busy_s[d]);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int len;
        len = (v.act == 2) ? 200 : WIN;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) begin
                en = 1'b1;
                if (v.push != 0) push_exp(cyc + WIN - 1, v);
            end
            tach[0] = pulse(k, v.n0, v.x0);
            tach[1] = pulse(k, v.n1, v.x1);
            if (k == 10 && v.busy10 >= 0) begin
                nvec++;
                if (busy_a !== 1'(v.busy10)) begin
                    nerr++;
                    $display("FAIL busy_at_10: got %b, required %0d", busy_a, v.busy10);
                end
            end
            if (k == 500) begin
                nvec++;
                if (busy_a !== 1'b0) begin
                    nerr++;
                    $display("FAIL busy_at_500: got %b, required 0", busy_a);
                end
            end
            if (v.act == 2 && k == v.cut) en = 1'b0;
            if (v.act == 1 && k == v.cut) begin
                rst  = 1'b1;
                en   = 1'b0;
                tach = 2'b00;
                for (int s = 0; s < 6; s++) q[s].delete();
                break;
            end
        end
        if (v.act == 1) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) check_idle(d);
            repeat (4) @(negedge clk);
            rst = 1'b0;
            repeat (20) @(negedge clk);
        end
    endtask

    // Monitor: pops the matching expectation whenever a channel strobes.
    always begin : mon
        exp_t e;
        int   s;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 2; c++) begin
                if (val_s[d][c] === 1'b1) begin
                    s = d * 2 + c;
                    nvec++;
                    if (q[s].size() == 0) begin
                        nerr++;
                        $display("FAIL strobe_d%0dc%0d: unexpected strobe at cycle %0d rpm=%0d, required none",
                                 d, c, cyc, rpm_s[d][c]);
                    end else begin
                        e = q[s].pop_front();
                        if (rpm_s[d][c] !== 21'(e.rpm) || sat_s[d][c] !== 1'(e.sat) || cyc != e.t_exp) begin
                            nerr++;
                            $display("FAIL strobe_d%0dc%0d: got rpm=%0d sat=%b cycle=%0d, required rpm=%0d sat=%0d cycle=%0d",
                                     d, c, rpm_s[d][c], sat_s[d][c], cyc, e.rpm, e.sat, e.t_exp);
                        end
                    end
                end
            end
            if (fd_s[d] === 1'b1 || val_s[d][1] === 1'b1) begin
                nvec++;
                if (fd_s[d] !== val_s[d][1]) begin
                    nerr++;
                    $display("FAIL frame_done_d%0d: got fd=%b with valid1=%b, required equal", d, fd_s[d], val_s[d][1]);
                end
            end
        end
    end

    vec_t vecs [9];

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        tach = 2'b00;
        //            n0   x0  n1   x1 act cut push b10  r0a s0a r1  r0b s0b r0c s0c
        vecs[0] = '{  60,  -1,  7,  -1, 0, -1, 1,  0,  100, 0, 11, 100, 0, 63, 1};
        vecs[1] = '{   0,  -1,  0,  -1, 0, -1, 1,  1,    0, 0,  0,   0, 0,  0, 0};
        vecs[2] = '{  60, 996,  7, 997, 0, -1, 1,  1,  101, 0, 11, 101, 0, 63, 1};
        vecs[3] = '{  30,  -1,  0,  -1, 0, -1, 1,  1,   50, 0,  1,  50, 0, 50, 0};
        vecs[4] = '{ 300,  -1,  0,  -1, 0, -1, 1,  1,  500, 0,  0, 424, 1, 63, 1};
        vecs[5] = '{   0,  -1,  0,  -1, 1, 10, 0, -1,    0, 0,  0,   0, 0,  0, 0};
        vecs[6] = '{  60,  -1,  7,  -1, 0, -1, 1,  0,  100, 0, 11, 100, 0, 63, 1};
        vecs[7] = '{  10,  -1,  0,  -1, 2, 30, 0,  1,    0, 0,  0,   0, 0,  0, 0};
        vecs[8] = '{   0,  -1,  0,  -1, 0, -1, 1,  0,    0, 0,  0,   0, 0,  0, 0};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        repeat (100) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        for (int s = 0; s < 6; s++) begin
            nvec++;
            if (q[s].size() != 0) begin
                nerr++;
                $display("FAIL drain_s%0d: %0d strobes still outstanding, required 0", s, q[s].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
